// File: rtl/output_beat_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : output_beat_serializer
// Description : Two-entry set buffer that captures 128-value output sets and
//               streams them as LANES-wide beats over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module output_beat_serializer #(
    parameter int DATA_WIDTH  = 4,
    parameter int DATA_OF_SET = 128,
    parameter int LANES       = 16,
    parameter int DEPTH       = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_OF_SET*DATA_WIDTH-1:0] din,
    input  logic                              din_valid,
    output logic [LANES*DATA_WIDTH-1:0]       m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic                              m_last,
    output logic                              overflow,
    output logic                              busy,
    output logic [15:0]                       sets_done
);

    localparam int c_SET_W   = DATA_OF_SET * DATA_WIDTH;
    localparam int c_BEAT_DW = LANES * DATA_WIDTH;
    localparam int c_BEATS   = DATA_OF_SET / LANES;
    localparam int c_BEAT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [c_SET_W-1:0]   r_mem [DEPTH];
    logic [1:0]           r_occ;
    logic [1:0]           w_occ_nxt;
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [c_BEAT_W-1:0]  r_beat;
    logic                 r_overflow;
    logic [15:0]          r_sets_done;

    logic                 w_valid;
    logic                 w_last;
    logic                 w_fire;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [c_SET_W-1:0]   w_head;
    logic [c_BEAT_DW-1:0] w_beats [c_BEATS];

    assign w_valid = (r_occ != c_OCC_EMPTY);
    assign w_last  = w_valid & (r_beat == c_LAST_BEAT);
    assign w_fire  = w_valid & m_ready;
    assign w_pop   = w_fire & w_last;
    assign w_full  = (r_occ == c_OCC_FULL);
    // A pop in the same cycle frees the head entry, so a write into a full buffer still lands.
    assign w_push  = din_valid & (~w_full | w_pop);
    assign w_drop  = din_valid & w_full & ~w_pop;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = (r_occ == c_OCC_EMPTY) ? c_OCC_ONE : c_OCC_FULL;
            2'b01:   w_occ_nxt = (r_occ == c_OCC_FULL) ? c_OCC_ONE : c_OCC_EMPTY;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ       <= c_OCC_EMPTY;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_beat      <= '0;
            r_overflow  <= 1'b0;
            r_sets_done <= 16'd0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_beat      <= '0;
                r_sets_done <= r_sets_done + 16'd1;
            end else if (w_fire) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Set storage carries no reset; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    for (genvar b = 0; b < c_BEATS; b++) begin : g_beat
        assign w_beats[b] = w_head[b*c_BEAT_DW +: c_BEAT_DW];
    end

    assign m_data    = w_beats[r_beat];
    assign m_valid   = w_valid;
    assign m_last    = w_last;
    assign busy      = w_valid;
    assign overflow  = r_overflow;
    assign sets_done = r_sets_done;

endmodule
`default_nettype wire

// File: tb/tb_output_beat_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_output_beat_serializer
// Description : Self-checking bench; a queue-of-sets model predicts the beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_beat_serializer;

    localparam int DW    = 4;
    localparam int NSET  = 128;
    localparam int LANES = 16;
    localparam int BEATS = NSET / LANES;
    localparam int SETW  = NSET * DW;
    localparam int BW    = LANES * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SETW-1:0] din = '0;
    logic            din_valid = 1'b0;
    logic            m_ready = 1'b0;
    logic [BW-1:0]   m_data;
    logic            m_valid;
    logic            m_last;
    logic            overflow;
    logic            busy;
    logic [15:0]     sets_done;

    always #5 clk = ~clk;

    output_beat_serializer #(
        .DATA_WIDTH (DW),
        .DATA_OF_SET(NSET),
        .LANES      (LANES),
        .DEPTH      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .overflow (overflow),
        .busy     (busy),
        .sets_done(sets_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of whole sets plus the index of the beat on offer.
    logic [SETW-1:0] q[$];
    int              mbeat = 0;
    logic            movf = 1'b0;
    logic [15:0]     mdone = 16'd0;

    function automatic logic exp_valid();
        return (q.size() != 0);
    endfunction

    function automatic logic exp_last();
        return (q.size() != 0) && (mbeat == BEATS - 1);
    endfunction

    function automatic logic [BW-1:0] exp_data();
        logic [SETW-1:0] h;
        if (q.size() == 0) return '0;
        h = q[0];
        return h[mbeat*BW +: BW];
    endfunction

    function automatic logic [SETW-1:0] fill(input logic [DW-1:0] v);
        logic [SETW-1:0] r;
        for (int i = 0; i < NSET; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [SETW-1:0] rand_set();
        logic [SETW-1:0] r;
        for (int w = 0; w < SETW / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        mbeat = 0;
        movf  = 1'b0;
        mdone = 16'd0;
    endtask

    // Advance one clock: model consumes the inputs seen at the edge, pop before write.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            if (q.size() != 0 && m_ready) begin
                if (mbeat == BEATS - 1) begin
                    void'(q.pop_front());
                    mbeat = 0;
                    mdone = mdone + 16'd1;
                end else begin
                    mbeat = mbeat + 1;
                end
            end
            if (din_valid) begin
                if (q.size() < 2) q.push_back(din);
                else movf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b last=%b busy=%b expected 0 0 0", m_valid, m_last, busy);
        end
        n_checks++;
        if (overflow !== 1'b0 || sets_done !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status: overflow=%b sets_done=%0d expected 0 0", overflow, sets_done);
        end
        rst = 1'b0;
        model_clear();
        tick();
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b busy=%b expected 0 0", m_valid, busy);
        end
    endtask

    task automatic test_single_set();
        logic [SETW-1:0] s;
        for (int i = 0; i < NSET; i++) s[i*DW +: DW] = DW'(i % 16);
        m_ready = 1'b1;
        din = s;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== 64'hFEDCBA9876543210 || m_last !== (k == BEATS - 1)) begin
                n_fail++;
                $display("FAIL single_beat%0d: valid=%b last=%b data=%h expected 1 %b fedcba9876543210",
                         k, m_valid, m_last, m_data, (k == BEATS - 1));
            end
            tick();
        end
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || sets_done !== 16'd1) begin
            n_fail++;
            $display("FAIL single_done: valid=%b busy=%b sets_done=%0d expected 0 0 1", m_valid, busy, sets_done);
        end
    endtask

    task automatic test_backpressure();
        logic [SETW-1:0] s;
        logic [BW-1:0]   pd;
        logic            plast;
        logic            pstall;
        int              xfers;
        for (int i = 0; i < NSET; i++) s[i*DW +: DW] = DW'(i % 16);
        xfers = 0;
        pstall = 1'b0;
        pd = '0;
        plast = 1'b0;
        m_ready = 1'b0;
        din = s;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < 40 && xfers < BEATS; c++) begin
            m_ready = (c % 3 == 0);
            n_checks++;
            if (m_valid !== exp_valid() || m_last !== exp_last() || (exp_valid() && m_data !== exp_data())) begin
                n_fail++;
                $display("FAIL bp_model c%0d: valid=%b last=%b data=%h expected %b %b %h",
                         c, m_valid, m_last, m_data, exp_valid(), exp_last(), exp_data());
            end
            if (pstall) begin
                n_checks++;
                if (m_data !== pd || m_last !== plast || m_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d: valid=%b data=%h last=%b expected 1 %h %b",
                             c, m_valid, m_data, m_last, pd, plast);
                end
            end
            pstall = m_valid && !m_ready;
            pd = m_data;
            plast = m_last;
            if (m_valid && m_ready) xfers++;
            tick();
        end
        n_checks++;
        if (xfers !== BEATS || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: transfers=%0d valid_after=%b expected %0d 0", xfers, m_valid, BEATS);
        end
    endtask

    task automatic test_two_sets();
        logic [SETW-1:0] a;
        logic [SETW-1:0] b;
        logic [BW-1:0]   seen[$];
        logic [BW-1:0]   e;
        int              first;
        int              last;
        a = fill(4'h3);
        b = fill(4'hC);
        first = -1;
        last = -1;
        m_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            din_valid = (c == 0 || c == 2);
            din = (c == 0) ? a : b;
            n_checks++;
            if (m_valid !== exp_valid() || m_last !== exp_last() || (exp_valid() && m_data !== exp_data())) begin
                n_fail++;
                $display("FAIL two_model c%0d: valid=%b last=%b data=%h expected %b %b %h",
                         c, m_valid, m_last, m_data, exp_valid(), exp_last(), exp_data());
            end
            if (m_valid && m_ready) begin
                seen.push_back(m_data);
                if (first < 0) first = c;
                last = c;
            end
            tick();
        end
        din_valid = 1'b0;
        n_checks++;
        if (seen.size() != 2 * BEATS || last - first != 2 * BEATS - 1) begin
            n_fail++;
            $display("FAIL two_stream: beats=%0d span=%0d expected %0d %0d", seen.size(), last - first, 2 * BEATS, 2 * BEATS - 1);
        end
        for (int i = 0; i < seen.size() && i < 2 * BEATS; i++) begin
            e = (i < BEATS) ? {LANES{4'h3}} : {LANES{4'hC}};
            n_checks++;
            if (seen[i] !== e) begin
                n_fail++;
                $display("FAIL two_beat%0d: got %h expected %h", i, seen[i], e);
            end
        end
        n_checks++;
        if (overflow !== 1'b0 || sets_done !== mdone) begin
            n_fail++;
            $display("FAIL two_status: overflow=%b sets_done=%0d expected 0 %0d", overflow, sets_done, mdone);
        end
    endtask

    task automatic test_simultaneous();
        logic [SETW-1:0] sets[3];
        logic [SETW-1:0] h;
        logic [BW-1:0]   seen[$];
        sets[0] = rand_set();
        sets[1] = rand_set();
        sets[2] = rand_set();
        for (int c = 0; c < 30; c++) begin
            din_valid = (c == 0 || c == 1 || c == 9);
            din = (c == 0) ? sets[0] : ((c == 1) ? sets[1] : sets[2]);
            m_ready = (c >= 2);
            if (c == 9) begin
                n_checks++;
                if (m_last !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sim_align: last=%b busy=%b expected 1 1", m_last, busy);
                end
            end
            n_checks++;
            if (m_valid !== exp_valid() || m_last !== exp_last() || (exp_valid() && m_data !== exp_data())) begin
                n_fail++;
                $display("FAIL sim_model c%0d: valid=%b last=%b data=%h expected %b %b %h",
                         c, m_valid, m_last, m_data, exp_valid(), exp_last(), exp_data());
            end
            if (m_valid && m_ready) seen.push_back(m_data);
            tick();
        end
        din_valid = 1'b0;
        n_checks++;
        if (seen.size() != 3 * BEATS || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_count: beats=%0d overflow=%b expected %0d 0", seen.size(), overflow, 3 * BEATS);
        end
        for (int i = 0; i < seen.size() && i < 3 * BEATS; i++) begin
            h = sets[i / BEATS];
            n_checks++;
            if (seen[i] !== h[(i % BEATS)*BW +: BW]) begin
                n_fail++;
                $display("FAIL sim_beat%0d: got %h expected %h", i, seen[i], h[(i % BEATS)*BW +: BW]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [SETW-1:0] sets[3];
        logic [SETW-1:0] h;
        logic [BW-1:0]   seen[$];
        sets[0] = rand_set();
        sets[1] = rand_set();
        sets[2] = rand_set();
        for (int c = 0; c < 30; c++) begin
            din_valid = (c < 3);
            din = sets[(c < 3) ? c : 2];
            m_ready = (c >= 5);
            if (c == 2 || c == 3) begin
                n_checks++;
                if (overflow !== (c == 3)) begin
                    n_fail++;
                    $display("FAIL ovr_flag c%0d: overflow=%b expected %b", c, overflow, (c == 3));
                end
            end
            n_checks++;
            if (m_valid !== exp_valid() || m_last !== exp_last() || (exp_valid() && m_data !== exp_data())) begin
                n_fail++;
                $display("FAIL ovr_model c%0d: valid=%b last=%b data=%h expected %b %b %h",
                         c, m_valid, m_last, m_data, exp_valid(), exp_last(), exp_data());
            end
            if (m_valid && m_ready) seen.push_back(m_data);
            tick();
        end
        din_valid = 1'b0;
        n_checks++;
        if (seen.size() != 2 * BEATS || m_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_count: beats=%0d valid=%b overflow=%b expected %0d 0 1",
                     seen.size(), m_valid, overflow, 2 * BEATS);
        end
        for (int i = 0; i < seen.size() && i < 2 * BEATS; i++) begin
            h = sets[i / BEATS];
            n_checks++;
            if (seen[i] !== h[(i % BEATS)*BW +: BW]) begin
                n_fail++;
                $display("FAIL ovr_beat%0d: got %h expected %h", i, seen[i], h[(i % BEATS)*BW +: BW]);
            end
        end
    endtask

    task automatic test_reset_mid_set();
        logic [SETW-1:0] a;
        logic [SETW-1:0] e;
        a = rand_set();
        e = rand_set();
        m_ready = 1'b1;
        din = a;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== a[3*BW +: BW]) begin
            n_fail++;
            $display("FAIL rmid_beat3: valid=%b data=%h expected 1 %h", m_valid, m_data, a[3*BW +: BW]);
        end
        #2 rst = 1'b1;
        #1;
        model_clear();
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || sets_done !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_async: valid=%b busy=%b last=%b sets_done=%0d overflow=%b expected all 0",
                     m_valid, busy, m_last, sets_done, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        din = e;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== e[k*BW +: BW] || m_last !== (k == BEATS - 1)) begin
                n_fail++;
                $display("FAIL rmid_new%0d: valid=%b last=%b data=%h expected 1 %b %h",
                         k, m_valid, m_last, m_data, (k == BEATS - 1), e[k*BW +: BW]);
            end
            tick();
        end
        n_checks++;
        if (sets_done !== 16'd1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_done: sets_done=%0d valid=%b expected 1 0", sets_done, m_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            din_valid = ($urandom_range(0, 9) == 0);
            din = rand_set();
            m_ready = ($urandom_range(0, 3) != 0);
            n_checks++;
            if (m_valid !== exp_valid() || busy !== exp_valid() || m_last !== exp_last()
                || (exp_valid() && m_data !== exp_data()) || overflow !== movf || sets_done !== mdone) begin
                n_fail++;
                $display("FAIL rand c%0d: valid=%b last=%b data=%h ovf=%b done=%0d expected %b %b %h %b %0d",
                         c, m_valid, m_last, m_data, overflow, sets_done,
                         exp_valid(), exp_last(), exp_data(), movf, mdone);
            end
            tick();
        end
        din_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2 * BEATS + 4) tick();
        n_checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || sets_done !== mdone) begin
            n_fail++;
            $display("FAIL rand_drain: valid=%b busy=%b sets_done=%0d expected 0 0 %0d", m_valid, busy, sets_done, mdone);
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_backpressure();
        test_two_sets();
        test_simultaneous();
        test_overrun();
        test_reset_mid_set();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
